// File: rtl/dmem_pkg.sv
// Shared sizes and the write-buffer entry type for the data-memory port
// with its store buffer.
package dmem_pkg;

    localparam int DMEM_WORDS = 64;
    localparam int WB_DEPTH   = 4;
    localparam int IDX_W      = 6;
    localparam int DATA_W     = 32;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 3;

    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Four-entry store FIFO with wrap-around pointers, occupancy count and a
// youngest-match lookup used for load forwarding or load blocking.
module wbuf_fifo
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  wb_entry_t         push_entry,
    input  logic              pop,
    input  logic [IDX_W-1:0]  lookup_index,
    output wb_entry_t         head_entry,
    output logic [CNT_W-1:0]  count,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    wb_entry_t        slots [WB_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] slot;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is legal only when the head leaves the same edge.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != CNT_W'(WB_DEPTH)) || pop_ok);

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop_ok) begin
                head <= head + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            slots[tail] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (count <= CNT_W'(WB_DEPTH));
        end
    end

    assign head_entry = slots[head];

    // Walk oldest to youngest so the last valid match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        slot     = head;
        for (int i = 0; i < WB_DEPTH; i++) begin
            slot = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (slots[slot].index == lookup_index)) begin
                hit      = 1'b1;
                hit_data = slots[slot].data;
            end
        end
    end

endmodule

// File: rtl/dmem_wbuf_port.sv
// Single-port 64x32 data memory fronted by a 4-entry write buffer.
// Define DMEM_WBUF_FWD_EN for store-to-load forwarding; otherwise matching loads stall.
module dmem_wbuf_port
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        memstall,
    output logic        wb_empty
);

    logic [DATA_W-1:0] mem [DMEM_WORDS];
    logic [IDX_W-1:0]  word_idx;
    logic              unused_addr_bits;
    wb_entry_t         push_entry;
    wb_entry_t         head_entry;
    logic [CNT_W-1:0]  wb_count;
    logic              wb_full;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic              load_blocked;
    logic              port_busy;
    logic              full_stall;
    logic              push;
    logic              pop;

    assign word_idx         = addr[7:2];
    assign unused_addr_bits = ^{addr[31:8], addr[1:0]};

    assign push_entry.index = word_idx;
    assign push_entry.data  = writedata;

    assign wb_full  = (wb_count == CNT_W'(WB_DEPTH));
    assign wb_empty = (wb_count == '0);

`ifdef DMEM_WBUF_FWD_EN
    assign load_blocked = 1'b0;
`else
    logic unused_hit_data;
    assign unused_hit_data = ^hit_data;
    // A load that would read stale data yields the port so the head can drain.
    assign load_blocked    = memread & hit;
`endif

    assign port_busy  = memread & ~load_blocked;
    assign full_stall = memwrite & wb_full & port_busy;
    assign memstall   = reset & (load_blocked | full_stall);
    assign push       = reset & memwrite & ~memstall;
    assign pop        = reset & ~wb_empty & ~port_busy;

    wbuf_fifo u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_entry   (push_entry),
        .pop          (pop),
        .lookup_index (word_idx),
        .head_entry   (head_entry),
        .count        (wb_count),
        .hit          (hit),
        .hit_data     (hit_data)
    );

    always_ff @(posedge clk) begin
        if (pop) begin
            mem[head_entry.index] <= head_entry.data;
        end
    end

    always_comb begin
        readdata = '0;
        if (reset && memread) begin
`ifdef DMEM_WBUF_FWD_EN
            if (hit) begin
                readdata = hit_data;
            end else begin
                readdata = mem[word_idx];
            end
`else
            if (!load_blocked) begin
                readdata = mem[word_idx];
            end
`endif
        end
    end

endmodule

// File: tb/tb_dmem_wbuf_port.sv
// Self-checking bench for dmem_wbuf_port: directed scenarios plus random
// traffic checked against a queue-based model of the store buffer.
module tb_dmem_wbuf_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        memstall;
    logic        wb_empty;

    int checks = 0;
    int errors = 0;

`ifdef DMEM_WBUF_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // Model: pending stores in program order, plus what the array should hold.
    logic [5:0]  q_idx [$];
    logic [31:0] q_dat [$];
    logic [31:0] mem_model [64];
    bit          mem_known [64];

    logic        exp_stall;
    logic        exp_empty;
    logic [31:0] exp_rdata;
    bit          exp_rknown;
    bit          nxt_clear;
    bit          nxt_drain;
    bit          nxt_push;
    logic [5:0]  nxt_idx;
    logic [31:0] nxt_dat;

    always #5 clk = ~clk;

    dmem_wbuf_port dut (
        .clk       (clk),
        .reset     (reset),
        .memread   (memread),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .memstall  (memstall),
        .wb_empty  (wb_empty)
    );

    // Apply one cycle of inputs, predict outputs, wait to mid-cycle.
    task automatic drive(input logic rst, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        logic [5:0]  idx;
        bit          match;
        logic [31:0] young;
        bit          load_stall;
        bit          port_used;
        reset     = rst;
        memread   = rd;
        memwrite  = wr;
        addr      = a;
        writedata = wd;
        idx   = a[7:2];
        match = 0;
        young = '0;
        foreach (q_idx[i]) begin
            if (q_idx[i] == idx) begin
                match = 1;
                young = q_dat[i];
            end
        end
        exp_empty  = (q_idx.size() == 0);
        exp_stall  = 1'b0;
        exp_rdata  = '0;
        exp_rknown = 1;
        nxt_clear  = !rst;
        nxt_drain  = 0;
        nxt_push   = 0;
        nxt_idx    = idx;
        nxt_dat    = wd;
        if (rst) begin
            load_stall = !FWD_EN && rd && match;
            port_used  = rd && !load_stall;
            exp_stall  = load_stall || (wr && q_idx.size() == 4 && port_used);
            if (rd && !load_stall) begin
                if (FWD_EN && match) begin
                    exp_rdata = young;
                end else begin
                    exp_rdata  = mem_model[idx];
                    exp_rknown = mem_known[idx];
                end
            end
            nxt_drain = (q_idx.size() > 0) && !port_used;
            nxt_push  = wr && !exp_stall;
        end
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        if (nxt_clear) begin
            q_idx.delete();
            q_dat.delete();
        end
        if (nxt_drain) begin
            mem_model[q_idx[0]] = q_dat[0];
            mem_known[q_idx[0]] = 1;
            void'(q_idx.pop_front());
            void'(q_dat.pop_front());
        end
        if (nxt_push) begin
            q_idx.push_back(nxt_idx);
            q_dat.push_back(nxt_dat);
        end
        #1;
    endtask

    task automatic settle();
        for (int c = 0; c < 8 && q_idx.size() > 0; c++) begin
            drive(1, 0, 0, 32'h0, 32'h0);
            tick();
        end
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 32'h0, 32'h0);
        tick();
        drive(0, 1, 1, 32'h10, 32'h1234);
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h exp 0", readdata); end
        checks++; if (memstall !== 1'b0) begin errors++; $display("FAIL reset_memstall got %b exp 0", memstall); end
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL reset_wb_empty got %b exp 1", wb_empty); end
        tick();
        drive(1, 0, 0, 32'h0, 32'h0);
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL reset_no_enqueue got %b exp 1", wb_empty); end
        tick();
    endtask

    task automatic test_load_basic();
        drive(1, 0, 1, 32'h10, 32'hAAAA5555);
        tick();
        settle();
        drive(1, 1, 0, 32'h10, 32'h0);
        checks++; if (readdata !== 32'hAAAA5555) begin errors++; $display("FAIL load_basic got %h exp aaaa5555", readdata); end
        checks++; if (memstall !== 1'b0) begin errors++; $display("FAIL load_basic_stall got %b exp 0", memstall); end
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL load_basic_empty got %b exp 1", wb_empty); end
        tick();
        // Upper and byte-offset address bits must not affect the word chosen.
        drive(1, 1, 0, 32'hFFFF_FF13, 32'h0);
        checks++; if (readdata !== 32'hAAAA5555) begin errors++; $display("FAIL load_addr_alias got %h exp aaaa5555", readdata); end
        tick();
    endtask

    task automatic test_forward_youngest();
        bit done = 0;
        settle();
        drive(1, 0, 1, 32'h20, 32'h11111111);
        tick();
        drive(1, 0, 1, 32'h20, 32'h22222222);
        tick();
        for (int c = 0; c < 6 && !done; c++) begin
            drive(1, 1, 0, 32'h20, 32'h0);
            checks++; if (memstall !== exp_stall) begin errors++; $display("FAIL fwd_youngest_stall got %b exp %b", memstall, exp_stall); end
            if (!exp_stall) begin
                checks++; if (readdata !== 32'h22222222) begin errors++; $display("FAIL fwd_youngest got %h exp 22222222", readdata); end
                done = 1;
            end
            tick();
        end
        if (!done) begin checks++; errors++; $display("FAIL fwd_youngest_timeout got stall exp completion"); end
    endtask

    task automatic test_full_stall();
        logic [31:0] d [5];
        settle();
        for (int i = 0; i < 5; i++) d[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 32'h40 + 32'(4 * i), d[i]);
            checks++; if (memstall !== 1'b0) begin errors++; $display("FAIL full_fill_stall[%0d] got %b exp 0", i, memstall); end
            tick();
        end
        drive(1, 1, 1, 32'h50, d[4]);
        checks++; if (memstall !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", memstall); end
        checks++; if (wb_empty !== 1'b0) begin errors++; $display("FAIL full_wb_empty got %b exp 0", wb_empty); end
        tick();
        drive(1, 0, 1, 32'h50, d[4]);
        checks++; if (memstall !== 1'b0) begin errors++; $display("FAIL full_release got %b exp 1'b0", memstall); end
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 32'h0, 32'h0);
            checks++; if (wb_empty !== 1'b0) begin errors++; $display("FAIL full_drain_empty[%0d] got %b exp 0", k, wb_empty); end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 32'h40 + 32'(4 * i), 32'h0);
            checks++; if (readdata !== d[i]) begin errors++; $display("FAIL full_array[%0d] got %h exp %h", i, readdata, d[i]); end
            tick();
        end
    endtask

    task automatic test_drain_timing();
        logic [31:0] d [4];
        settle();
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            drive(1, 1, 1, 32'h80 + 32'(4 * i), d[i]);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 32'h0, 32'h0);
            checks++; if (wb_empty !== 1'b0) begin errors++; $display("FAIL drain_edge[%0d] got %b exp 0", k, wb_empty); end
            tick();
        end
        drive(1, 0, 0, 32'h0, 32'h0);
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL drain_done got %b exp 1", wb_empty); end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 32'h80 + 32'(4 * i), 32'h0);
            checks++; if (readdata !== d[i]) begin errors++; $display("FAIL drain_array[%0d] got %h exp %h", i, readdata, d[i]); end
            tick();
        end
    endtask

    task automatic test_load_after_store();
        logic [31:0] v;
        settle();
        v = $urandom;
        drive(1, 0, 1, 32'h30, v);
        tick();
`ifndef DMEM_WBUF_FWD_EN
        drive(1, 1, 0, 32'h30, 32'h0);
        checks++; if (memstall !== 1'b1) begin errors++; $display("FAIL las_stall got %b exp 1", memstall); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL las_suppress got %h exp 0", readdata); end
        tick();
`endif
        drive(1, 1, 0, 32'h30, 32'h0);
        checks++; if (memstall !== 1'b0) begin errors++; $display("FAIL las_complete_stall got %b exp 0", memstall); end
        checks++; if (readdata !== v) begin errors++; $display("FAIL las_data got %h exp %h", readdata, v); end
        tick();
    endtask

    task automatic test_reset_discard();
        logic [31:0] old_v [3];
        settle();
        for (int i = 0; i < 3; i++) begin
            old_v[i] = $urandom;
            drive(1, 0, 1, 32'hA0 + 32'(4 * i), old_v[i]);
            tick();
        end
        settle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 32'hA0 + 32'(4 * i), ~old_v[i]);
            tick();
        end
        drive(1, 0, 0, 32'h0, 32'h0);
        checks++; if (wb_empty !== 1'b0) begin errors++; $display("FAIL discard_pending got %b exp 0", wb_empty); end
        // Held reset must discard, not drain, even though memread is low.
        drive(0, 0, 0, 32'h0, 32'h0);
        tick();
        drive(1, 0, 0, 32'h0, 32'h0);
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL discard_empty got %b exp 1", wb_empty); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 32'hA0 + 32'(4 * i), 32'h0);
            checks++; if (readdata !== old_v[i]) begin errors++; $display("FAIL discard_array[%0d] got %h exp %h", i, readdata, old_v[i]); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        rst;
        logic        rd;
        logic        wr;
        for (int n = 0; n < 400; n++) begin
            a      = $urandom;
            a[7:2] = 6'($urandom_range(0, 7));
            rst    = ($urandom_range(0, 59) != 0);
            rd     = 1'($urandom_range(0, 1));
            wr     = 1'($urandom_range(0, 1));
            drive(rst, rd, wr, a, $urandom);
            checks++; if (memstall !== exp_stall) begin errors++; $display("FAIL rand_stall n=%0d got %b exp %b", n, memstall, exp_stall); end
            checks++; if (wb_empty !== exp_empty) begin errors++; $display("FAIL rand_empty n=%0d got %b exp %b", n, wb_empty, exp_empty); end
            if (exp_rknown) begin
                checks++; if (readdata !== exp_rdata) begin errors++; $display("FAIL rand_readdata n=%0d got %h exp %h", n, readdata, exp_rdata); end
            end
            tick();
        end
    endtask

    initial begin
        reset     = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        addr      = '0;
        writedata = '0;
        foreach (mem_known[i]) mem_known[i] = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_basic();
        test_forward_youngest();
        test_full_stall();
        test_drain_timing();
        test_load_after_store();
        test_reset_discard();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
